i2s_tx: RTL
===========

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SLOT_BITS, default 32: bclk cycles per channel slot; legal range 25..64.
REQ-002 Parameter OVF_HOLD, default 4800: frames clip_led stays high after an overflow is sampled; legal range >=1.
REQ-003 bclk  input  1  bit clock; the only clock, all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  run request: 1 = generate frames, 0 = stop after the current frame.
REQ-006 mute  input  1  when 1, zero is transmitted in place of sample.
REQ-007 sample  input  24  signed mono sample, two's complement.
REQ-008 overflow  input  1  overflow flag accompanying sample.
REQ-009 lrck  output  1  word select: 0 = left slot, 1 = right slot; also clocks the sample producer.
REQ-010 sdata  output  1  I2S serial data, MSB first, one-bclk delay after each lrck edge.
REQ-011 clip_led  output  1  stretched overflow indicator.
REQ-012 frame_count  output  16  count of frames started since reset, wraps.
REQ-013 busy  output  1  1 when state is RUN or STOP.

Function
REQ-014 The block SHALL implement states IDLE, RUN, STOP; cnt is a slot counter 0..2*SLOT_BITS-1.
REQ-015 In IDLE: cnt held at 0, lrck=0, sdata=0, no captures; en=1 sampled -> RUN at the next edge, with that edge counting as a frame start.
REQ-016 In RUN and STOP, cnt SHALL increment every bclk and wrap from 2*SLOT_BITS-1 to 0; each edge entering cnt=0 is a frame start.
REQ-017 lrck SHALL be 0 while cnt<SLOT_BITS and 1 otherwise, registered, transitioning on the same edge as cnt.
REQ-018 At each frame start the block SHALL latch sample into a 24-bit hold register (zero when mute=1), increment frame_count modulo 2^16, and sample overflow.
REQ-019 sdata SHALL be 0 at cnt=0 and cnt=SLOT_BITS.
REQ-020 For k=1..24, sdata SHALL be hold bit 24-k at cnt=k and again at cnt=SLOT_BITS+k; both channels carry the same sample.
REQ-021 sdata SHALL be 0 for all remaining counts in each slot.
REQ-022 sdata, lrck and busy SHALL be registered and change only on rising bclk; the DAC samples on falling bclk.
REQ-023 Hold-register contents SHALL NOT change mid-frame; sample and mute changes take effect at the next frame start only.
REQ-024 RUN with en=0 -> STOP; STOP with en=1 -> RUN with no change to cnt and no frame break.
REQ-025 STOP SHALL complete the current frame; at the wrap edge it enters IDLE with cnt=0, lrck=0, sdata=0 and no capture.
REQ-026 en toggled inside one frame SHALL never shorten a frame: every frame begun is exactly 2*SLOT_BITS cycles.
REQ-027 clip_led: a 13+ bit hold counter loads OVF_HOLD at any frame start with overflow=1.
REQ-028 The hold counter decrements at each other frame start while nonzero.
REQ-029 clip_led SHALL equal (hold counter != 0).
REQ-030 The hold counter SHALL freeze in IDLE.
REQ-031 An overflow arriving while the hold counter is nonzero SHALL reload it to OVF_HOLD (retrigger).

Reset
REQ-032 rst_n=0 SHALL immediately, without bclk, force state=IDLE, cnt=0, lrck=0, sdata=0, clip_led=0, hold counter=0, frame_count=0, busy=0, and hold register=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame without completing it.
REQ-034 After rst_n deasserts, the first en=1 sampled SHALL start a frame per REQ-015.

Verification
REQ-035 SLOT_BITS=32, en=1, sample=24'hA5A5A5 -> 64-cycle frames; lrck 32 low/32 high; sdata at cnt 1..24 and 33..56 = 1010_0101 repeated; other counts 0.
REQ-036 sample changed from 24'h000001 to 24'h7FFFFF at cnt=10 -> current frame still sends 000001; next frame sends 7FFFFF.
REQ-037 en dropped at cnt=5 -> frame runs to cnt=63, then IDLE with busy=0 and lrck=0; en re-raised at cnt=40 during STOP -> continuous frames with no gap.
REQ-038 OVF_HOLD=3, overflow=1 at frame 0 only -> clip_led high during frames 0..3 and low from frame 4; retrigger at frame 2 extends it through frame 5.
REQ-039 rst_n pulsed low at cnt=20 asynchronously -> all outputs 0 before the next bclk edge; frame_count=0 after release.
REQ-040 mute=1 with sample=24'h800000 -> all sdata bits 0 while lrck and frame_count proceed normally.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: mono I2S transmitter clocked entirely by bclk.
// One frame is 2*SLOT_BITS bclk cycles (left slot, then right slot).
// A 24-bit sample is captured at each frame start and sent MSB first in both
// slots, one bclk after each lrck edge. clip_led stretches a sampled overflow
// across the overflow frame plus the OVF_HOLD frames that follow it.
//
// Handshake: none. sample/mute/overflow are treated as level inputs and are
// sampled only on the bclk edge that starts a frame. The producer uses lrck
// as its clock, so its data is stable at the frame-start edge.
module i2s_tx #(
  parameter int SLOT_BITS = 32,
  parameter int OVF_HOLD  = 4800
) (
  input  logic        bclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mute,
  input  logic [23:0] sample,
  input  logic        overflow,
  output logic        lrck,
  output logic        sdata,
  output logic        clip_led,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_BITS);
  localparam logic [15:0]   HOLD_LD  = 16'(OVF_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [23:0]   hold;
  logic [15:0]   ovf_cnt;
  logic          frame_start;

  assign dbg_state = state;

  // Serial bit for a given slot count: data at counts 1..24 of each slot.
  function automatic logic bit_at(input logic [CW-1:0] c, input logic [23:0] h);
    logic [4:0] idx;
    logic       b;
    b   = 1'b0;
    idx = 5'd0;
    if (c >= CW'(1) && c <= CW'(24)) begin
      idx = 5'(24 - int'(c));
      b   = h[idx];
    end else if (c >= CW'(SLOT_BITS + 1) && c <= CW'(SLOT_BITS + 24)) begin
      idx = 5'(SLOT_BITS + 24 - int'(c));
      b   = h[idx];
    end
    return b;
  endfunction

  // Frame start: leaving IDLE on en, or wrapping while en is still requested.
  always_comb begin
    cnt_inc     = cnt + 1'b1;
    frame_start = 1'b0;
    if (state == IDLE)
      frame_start = en;
    else if (cnt == CNT_LAST)
      frame_start = en;
  end

  // Control FSM: slot counter and registered serial outputs.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lrck  <= 1'b0;
      sdata <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          lrck  <= 1'b0;
          sdata <= 1'b0;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        RUN, STOP: begin
          if (cnt == CNT_LAST) begin
            // End of frame: either chain straight into the next one or park.
            cnt   <= '0;
            lrck  <= 1'b0;
            sdata <= 1'b0;
            if (en) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt   <= cnt_inc;
            lrck  <= (cnt_inc >= CNT_SLOT);
            sdata <= bit_at(cnt_inc, hold);
            state <= en ? RUN : STOP;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          lrck  <= 1'b0;
          sdata <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Frame-start captures: sample hold, frame counter, overflow stretcher.
  // clip_led reflects the hold count before this frame's decrement, so the
  // frame in which the counter expires is still lit.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      frame_count <= '0;
      ovf_cnt     <= '0;
      clip_led    <= 1'b0;
    end else if (frame_start) begin
      hold        <= mute ? 24'd0 : sample;
      frame_count <= frame_count + 16'd1;
      clip_led    <= overflow || (ovf_cnt != 16'd0);
      if (overflow)
        ovf_cnt <= HOLD_LD;
      else if (ovf_cnt != 16'd0)
        ovf_cnt <= ovf_cnt - 16'd1;
    end
  end

endmodule
